hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Sequences the decode stage of the pipelined core by tracking in-flight register writes from decode until writeback. It compares the decode instruction's source registers against a shift-register scoreboard of pending destinations. On a match it stalls decode/fetch and injects a bubble into EX. It also honours a global memory freeze and a branch flush, and keeps a saturating hazard-stall performance counter.

Parameters:
DEPTH, 3, scoreboard stages between decode and register-file write (stage 0 = EX, stage DEPTH-1 = WB); legal 2..6
BYPASS_WB, 0, 1 = register file forwards same-cycle WB data, so the WB stage is excluded from hazard match; 0 = no bypass, so WB matches stall
FLUSH_STAGES, 0, number of youngest scoreboard stages (0..DEPTH-1) invalidated on flush, in addition to the decode instruction

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
id_valid  in  1  decode holds a valid instruction
id_rs  in  3  source register A (instruction[10:8])
id_rs_use  in  1  instruction reads id_rs
id_rt  in  3  source register B (instruction[7:5])
id_rt_use  in  1  instruction reads id_rt
id_rd  in  3  destination register (decode write-register select, includes R7 for JAL)
id_reg_wrt  in  1  decode instruction writes the register file
mem_stall  in  1  memory not ready; whole pipeline frozen this cycle
flush  in  1  branch/jump taken; kill decode instruction plus FLUSH_STAGES youngest stages
stall_id  out  1  hold PC and IF/ID register this cycle
bubble  out  1  load a NOP into ID/EX this cycle
pend_mask  out  8  bit r = 1 if any valid stage holds destination r
stall_cnt  out  16  count of hazard-stall cycles, saturating

Behaviour:
- State: DEPTH entries {v, reg[2:0]} plus stall_cnt. Async rst clears all v to 0 and stall_cnt to 0 immediately, independent of clk.
- After reset: pend_mask = 0, bubble = 0, stall_id = mem_stall.
- match(x): OR over stages i = 0..DEPTH-1 (i = 0..DEPTH-2 if BYPASS_WB = 1) of v[i] & (reg[i] == x).
- hazard = id_valid & !flush & ((id_rs_use & match(id_rs)) | (id_rt_use & match(id_rt))). Combinational, same cycle.
- stall_id = hazard | mem_stall.
- bubble = hazard & !mem_stall.
- pend_mask is combinational over all DEPTH stages, regardless of BYPASS_WB.
- Advance (posedge, mem_stall = 0):
  - entry[i+1] <= entry[i] for i = 0..DEPTH-2; entry[DEPTH-1] retires.
  - entry[0] <= {1, id_rd} iff id_valid & id_reg_wrt & !hazard & !flush; otherwise v[0] <= 0.
- Freeze (posedge, mem_stall = 1): all entries hold. No insertion, no retire.
- Flush (posedge, flush = 1):
  - Decode instruction is never inserted.
  - Entries in stages 0..FLUSH_STAGES-1 are invalidated before shifting, so they do not propagate.
  - If mem_stall is also 1, those stages are invalidated in place and all other entries hold.
- Simultaneous hazard and mem_stall: stall_id = 1, bubble = 0, stall_cnt holds.
- stall_cnt increments by 1 on each posedge where bubble = 1. It holds at 16'hFFFF (no wrap).
- Same register written by multiple in-flight entries: each entry is tracked independently. Hazard persists until the last matching entry leaves the match window.
- A decode instruction that writes a register it also reads (e.g. ADDI r1,r1): the match uses only older entries; its own rd is inserted after the hazard clears.
- Latency: a reader immediately following a writer stalls DEPTH cycles (BYPASS_WB = 0) or DEPTH-1 cycles (BYPASS_WB = 1), excluding mem_stall cycles.
- R0 is an ordinary register (no hardwired zero).

Test Plan:
- DEPTH=3, BYPASS_WB=0: cycle 0 writer id_rd=1, id_reg_wrt=1; cycle 1 reader id_rs=1, id_rs_use=1 -> stall_id=bubble=1 for cycles 1-3; reader proceeds in cycle 4; stall_cnt=3; pend_mask=0x02 during cycles 1-3.
- Same sequence with BYPASS_WB=1 -> stall exactly 2 cycles (1-2); stall_cnt=2.
- Writer with id_reg_wrt=0 (store, rd=2), then reader of r2 -> no stall; pend_mask stays 0x00. Also rs matches with id_rs_use=0 -> no stall.
- r4 pending in stage 0, mem_stall=1 for 2 cycles -> pend_mask=0x10 unchanged, entries frozen, bubble=0, stall_cnt unchanged; reader of r4 then stalls the normal remaining DEPTH cycles.
- flush=1 with writer rd=5 in decode (FLUSH_STAGES=0) -> not inserted; next-cycle reader of r5 -> no stall. With FLUSH_STAGES=1 and r6 in stage 0 -> r6 removed; pend_mask bit 6 clears next cycle.
- rst pulsed asynchronously mid-stall with pend_mask=0x06 -> pend_mask=0, stall_id=0 (mem_stall=0), stall_cnt=0 before the next clk edge; force stall_cnt to 16'hFFFF and hazard -> stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Decode hazard scoreboard: tracks in-flight register writes from EX to WB and stalls
// decode on a source match, with memory freeze, branch flush and a saturating stall counter.
module hazard_scoreboard #(
  parameter int DEPTH        = 3,
  parameter bit BYPASS_WB    = 1'b0,
  parameter int FLUSH_STAGES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_rs,
  input  logic        id_rs_use,
  input  logic [2:0]  id_rt,
  input  logic        id_rt_use,
  input  logic [2:0]  id_rd,
  input  logic        id_reg_wrt,
  input  logic        mem_stall,
  input  logic        flush,
  output logic        stall_id,
  output logic        bubble,
  output logic [7:0]  pend_mask,
  output logic [15:0] stall_cnt
);

  // With WB bypass the last stage's data is forwarded, so it never causes a stall.
  localparam int MATCH_N = BYPASS_WB ? DEPTH - 1 : DEPTH;
  localparam logic [DEPTH-1:0] FLUSH_MASK = DEPTH'((1 << FLUSH_STAGES) - 1);

  logic [DEPTH-1:0] v_q, v_d, v_live;
  logic [2:0]       rd_q [DEPTH];
  logic [2:0]       rd_d [DEPTH];
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             rs_hit, rt_hit, hazard, insert;

  always_comb begin
    rs_hit    = 1'b0;
    rt_hit    = 1'b0;
    pend_mask = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (v_q[i]) begin
        pend_mask[rd_q[i]] = 1'b1;
        if (i < MATCH_N && rd_q[i] == id_rs) rs_hit = 1'b1;
        if (i < MATCH_N && rd_q[i] == id_rt) rt_hit = 1'b1;
      end
    end
  end

  assign hazard   = id_valid & ~flush & ((id_rs_use & rs_hit) | (id_rt_use & rt_hit));
  assign stall_id = hazard | mem_stall;
  assign bubble   = hazard & ~mem_stall;
  assign insert   = id_valid & id_reg_wrt & ~hazard & ~flush;

  // Flush kills the youngest stages first, so under a freeze they vanish in place.
  always_comb begin
    v_live = flush ? (v_q & ~FLUSH_MASK) : v_q;
    v_d    = v_live;
    rd_d   = rd_q;
    if (!mem_stall) begin
      v_d[0]  = insert;
      rd_d[0] = id_rd;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i]  = v_live[i-1];
        rd_d[i] = rd_q[i-1];
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bubble && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      stall_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
    end else begin
      v_q         <= v_d;
      stall_cnt_q <= stall_cnt_d;
      rd_q        <= rd_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (plain, WB bypass, one-stage flush) share
// stimulus; per-cycle expected outputs are queued when driven and popped when sampled.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs_use, id_rt_use, id_reg_wrt, mem_stall, flush;
  logic [2:0]  id_rs, id_rt, id_rd;
  logic [2:0]  sid, bub;
  logic [7:0]  pm  [3];
  logic [15:0] cnt [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [2:0]      care;
    logic [2:0]      sid;
    logic [2:0]      bub;
    logic [2:0][7:0] pm;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .BYPASS_WB(1'b0), .FLUSH_STAGES(0)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
    .id_rt(id_rt), .id_rt_use(id_rt_use), .id_rd(id_rd), .id_reg_wrt(id_reg_wrt),
    .mem_stall(mem_stall), .flush(flush), .stall_id(sid[0]), .bubble(bub[0]),
    .pend_mask(pm[0]), .stall_cnt(cnt[0]));

  hazard_scoreboard #(.DEPTH(3), .BYPASS_WB(1'b1), .FLUSH_STAGES(0)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
    .id_rt(id_rt), .id_rt_use(id_rt_use), .id_rd(id_rd), .id_reg_wrt(id_reg_wrt),
    .mem_stall(mem_stall), .flush(flush), .stall_id(sid[1]), .bubble(bub[1]),
    .pend_mask(pm[1]), .stall_cnt(cnt[1]));

  hazard_scoreboard #(.DEPTH(3), .BYPASS_WB(1'b0), .FLUSH_STAGES(1)) dut_f (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
    .id_rt(id_rt), .id_rt_use(id_rt_use), .id_rd(id_rd), .id_reg_wrt(id_reg_wrt),
    .mem_stall(mem_stall), .flush(flush), .stall_id(sid[2]), .bubble(bub[2]),
    .pend_mask(pm[2]), .stall_cnt(cnt[2]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsu,
                       input logic [2:0] rt, input logic rtu, input logic [2:0] rd,
                       input logic wrt, input logic ms, input logic fl);
    id_valid = v;  id_rs = rs;  id_rs_use = rsu;  id_rt = rt;  id_rt_use = rtu;
    id_rd = rd;    id_reg_wrt = wrt;  mem_stall = ms;  flush = fl;
  endtask

  task automatic idle();              drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [2:0] r);   drive(1, 0, 0, 0, 0, r, 1, 0, 0); endtask
  task automatic rdrs(input logic [2:0] r); drive(1, r, 1, 0, 0, 0, 0, 0, 0); endtask

  // Bit order in care/s/b: {F, B, A}.
  task automatic expect_out(input logic [2:0] care, input logic [2:0] s, input logic [2:0] b,
                            input logic [7:0] pa, input logic [7:0] pb, input logic [7:0] pf);
    exp_t e;
    e.care = care;  e.sid = s;  e.bub = b;  e.pm = {pf, pb, pa};
    exp_q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    #2;
    if (exp_q.size() == 0) begin
      chk($sformatf("c%0d_queue_empty", cyc), 16'd1, 16'd0);
    end else begin
      e = exp_q.pop_front();
      for (int i = 0; i < 3; i++) begin
        if (e.care[i]) begin
          chk($sformatf("c%0d_i%0d_stall_id", cyc, i), 16'(sid[i]), 16'(e.sid[i]));
          chk($sformatf("c%0d_i%0d_bubble", cyc, i), 16'(bub[i]), 16'(e.bub[i]));
          chk($sformatf("c%0d_i%0d_pend_mask", cyc, i), 16'(pm[i]), 16'(e.pm[i]));
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic tick();
    compare();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] f);
    chk({tag, "_cnt_a"}, cnt[0], a);
    chk({tag, "_cnt_b"}, cnt[1], b);
    chk({tag, "_cnt_f"}, cnt[2], f);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    @(negedge clk);

    // Reset state: stall_id follows mem_stall only.
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_out(3'b111, 3'b111, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    chk_cnt("reset", 16'd0, 16'd0, 16'd0);

    // Writer then back-to-back reader.
    wr(1);   expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    rdrs(1); expect_out(3'b111, 3'b111, 3'b111, 8'h02, 8'h02, 8'h02); tick();
    rdrs(1); expect_out(3'b111, 3'b111, 3'b111, 8'h02, 8'h02, 8'h02); tick();
    rdrs(1); expect_out(3'b111, 3'b101, 3'b101, 8'h02, 8'h02, 8'h02); tick();
    rdrs(1); expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    chk_cnt("raw", 16'd3, 16'd2, 16'd3);

    // Store is not tracked; unused source fields never match; rt path does.
    do_reset();
    drive(1, 0, 0, 0, 0, 2, 0, 0, 0); expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    rdrs(2); expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    wr(3);   expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    drive(1, 3, 0, 3, 0, 0, 0, 0, 0); expect_out(3'b111, 3'b000, 3'b000, 8'h08, 8'h08, 8'h08); tick();
    drive(1, 0, 0, 3, 1, 0, 0, 0, 0); expect_out(3'b111, 3'b111, 3'b111, 8'h08, 8'h08, 8'h08); tick();
    chk_cnt("rt", 16'd1, 16'd1, 16'd1);

    // Memory freeze holds entries; hazard under freeze gives no bubble.
    do_reset();
    wr(4); expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_out(3'b111, 3'b111, 3'b000, 8'h10, 8'h10, 8'h10); tick();
    drive(1, 4, 1, 0, 0, 0, 0, 1, 0); expect_out(3'b111, 3'b111, 3'b000, 8'h10, 8'h10, 8'h10); tick();
    chk_cnt("freeze", 16'd0, 16'd0, 16'd0);
    rdrs(4); expect_out(3'b111, 3'b111, 3'b111, 8'h10, 8'h10, 8'h10); tick();
    rdrs(4); expect_out(3'b111, 3'b111, 3'b111, 8'h10, 8'h10, 8'h10); tick();
    rdrs(4); expect_out(3'b111, 3'b101, 3'b101, 8'h10, 8'h10, 8'h10); tick();
    rdrs(4); expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    chk_cnt("post_freeze", 16'd3, 16'd2, 16'd3);

    // Flush drops the decode writer; with one flush stage the EX entry is killed too.
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 1); expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    rdrs(5); expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    wr(6);   expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    drive(1, 6, 1, 0, 0, 7, 1, 0, 1); expect_out(3'b111, 3'b000, 3'b000, 8'h40, 8'h40, 8'h40); tick();
    idle();  expect_out(3'b111, 3'b000, 3'b000, 8'h40, 8'h40, 8'h00); tick();
    do_reset();
    wr(6);   expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    drive(1, 6, 1, 0, 0, 7, 1, 1, 1); expect_out(3'b111, 3'b111, 3'b000, 8'h40, 8'h40, 8'h40); tick();
    idle();  expect_out(3'b111, 3'b000, 3'b000, 8'h40, 8'h40, 8'h00); tick();

    // Asynchronous reset in the middle of a stall.
    do_reset();
    wr(1);   expect_out(3'b111, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    wr(2);   expect_out(3'b111, 3'b000, 3'b000, 8'h02, 8'h02, 8'h02); tick();
    rdrs(1); expect_out(3'b111, 3'b111, 3'b111, 8'h06, 8'h06, 8'h06); tick();
    rdrs(1); expect_out(3'b111, 3'b101, 3'b101, 8'h06, 8'h06, 8'h06); compare();
    rst = 1'b1;
    #1;
    chk("arst_pend_mask", 16'(pm[0]), 16'h0000);
    chk("arst_stall_id", 16'(sid[0]), 16'h0000);
    chk("arst_bubble", 16'(bub[0]), 16'h0000);
    chk("arst_stall_cnt", cnt[0], 16'h0000);
    rst = 1'b0;
    advance();

    // Counter saturation.
    do_reset();
    idle();
    force dut_a.stall_cnt_q = 16'hFFFF;
    #1;
    release dut_a.stall_cnt_q;
    expect_out(3'b001, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    chk("sat_preset", cnt[0], 16'hFFFF);
    wr(1);   expect_out(3'b001, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00); tick();
    rdrs(1); expect_out(3'b001, 3'b001, 3'b001, 8'h02, 8'h00, 8'h00); tick();
    rdrs(1); expect_out(3'b001, 3'b001, 3'b001, 8'h02, 8'h00, 8'h00); tick();
    chk("sat_hold", cnt[0], 16'hFFFF);

    idle();
    if (exp_q.size() != 0) chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
